// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle main control unit: opcodes, ALU-op
// codes (also consumed by the ALU control decoder), mux selects, states.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b010;
  localparam logic [2:0] ALU_SUBI  = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b100;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_IMM_EXEC  = 4'd9,
    ST_IMM_WB    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_JR        = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction-register / memory handshake inputs and datapath control
// outputs of the multicycle control unit. master = control unit side.
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_source;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_dbg;
  logic             illegal_op;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_count, state_dbg, illegal_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_count, state_dbg, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-vector lookup. Only FETCH looks at
// mem_ready (IR/PC load happen on the cycle the fetch completes).
import multicycle_control_fsm_pkg::*;

module multicycle_ctrl_decode (
  input  state_t state,
  input  logic   is_subi,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode of the control vector; unlisted states drive all zeros
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_RTYPE;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      ST_IMM_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = is_subi ? ALU_SUBI : ALU_ADDI;
      end
      ST_IMM_WB: ctrl.reg_write = 1'b1;
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      ST_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control FSM: next-state logic, opcode latch, retired
// instruction counter and illegal-opcode flag.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes park in TRAP).
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 on mem_ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | effective address for lw/sw
// MEM_READ  | lw data read, waits for mem_ready
// MEM_WB    | lw writeback from MDR
// MEM_WRITE | sw store, waits for mem_ready
// R_EXEC    | R-type ALU operation
// R_WB      | R-type writeback to rd
// BRANCH    | beq compare, conditional PC load
// IMM_EXEC  | addi/subi ALU operation
// IMM_WB    | immediate writeback to rt
// JUMP      | PC <- jump target
// JR        | PC <- rs
// TRAP      | illegal opcode parked (ILLEGAL_TRAP_EN only)
import multicycle_control_fsm_pkg::*;

module multicycle_control_fsm #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] SUBI_OP = OP_SUBI
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_control_fsm_if.master bus
);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  ctrl_t            ctrl;
  ctrl_t            ctrl_g;

  // Next state and retire strobe; DECODE dispatches on the live IR opcode
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:     if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = ST_MEM_ADDR;
        else if (bus.opcode == OP_R)
          state_d = (bus.funct == FUNCT_JR) ? ST_JR : ST_R_EXEC;
        else if (bus.opcode == OP_BEQ) state_d = ST_BRANCH;
        else if (bus.opcode == OP_ADDI || bus.opcode == SUBI_OP) state_d = ST_IMM_EXEC;
        else if (bus.opcode == OP_J) state_d = ST_JUMP;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      ST_MEM_ADDR:  state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    begin state_d = ST_FETCH; retire = 1'b1; end
      ST_MEM_WRITE: if (bus.mem_ready) begin state_d = ST_FETCH; retire = 1'b1; end
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      begin state_d = ST_FETCH; retire = 1'b1; end
      ST_BRANCH:    begin state_d = ST_FETCH; retire = 1'b1; end
      ST_IMM_EXEC:  state_d = ST_IMM_WB;
      ST_IMM_WB:    begin state_d = ST_FETCH; retire = 1'b1; end
      ST_JUMP:      begin state_d = ST_FETCH; retire = 1'b1; end
      ST_JR:        begin state_d = ST_FETCH; retire = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:      state_d = ST_TRAP;
`endif
      default:      state_d = ST_FETCH;
    endcase
  end

  // State register, opcode latch and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= bus.opcode;
      if (retire) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag set on the DECODE -> TRAP transition
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (state_q == ST_DECODE && state_d == ST_TRAP) illegal_q <= 1'b1;
  end

  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .is_subi   (op_q == SUBI_OP),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset forces every control strobe low, even mid-instruction
  assign ctrl_g = reset ? '0 : ctrl;

  assign bus.pc_write      = ctrl_g.pc_write;
  assign bus.pc_write_cond = ctrl_g.pc_write_cond;
  assign bus.i_or_d        = ctrl_g.i_or_d;
  assign bus.mem_read      = ctrl_g.mem_read;
  assign bus.mem_write     = ctrl_g.mem_write;
  assign bus.ir_write      = ctrl_g.ir_write;
  assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
  assign bus.reg_dst       = ctrl_g.reg_dst;
  assign bus.reg_write     = ctrl_g.reg_write;
  assign bus.alu_src_a     = ctrl_g.alu_src_a;
  assign bus.alu_src_b     = ctrl_g.alu_src_b;
  assign bus.alu_op        = ctrl_g.alu_op;
  assign bus.pc_source     = ctrl_g.pc_source;
  assign bus.instr_count   = count_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its
// expected per-cycle state walk from the latency/wait rules, and a negedge
// process compares state, control vector, counter and illegal flag.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_fsm #(.CNT_W(CNT_W), .SUBI_OP(6'b001001)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic             exp_valid = 1'b0;
  int               exp_state;
  logic [16:0]      exp_ctrl;
  logic [CNT_W-1:0] exp_count;
  logic             exp_illegal;
  logic [CNT_W-1:0] cnt_model = '0;
  logic             ill_model = 1'b0;

  logic [16:0] act_ctrl;
  assign act_ctrl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source};

  // Control table straight from the per-state description
  function automatic logic [16:0] ctrl_for(int st, int rdy, int subi);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      0:  begin mr = 1'b1; sb = 2'b01; pw = (rdy != 0); irw = (rdy != 0); end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin sa = 1'b1; ao = 3'b100; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin sa = 1'b1; ao = 3'b001; pwc = 1'b1; ps = 2'b01; end
      9:  begin sa = 1'b1; sb = 2'b10; ao = (subi != 0) ? 3'b011 : 3'b010; end
      10: rw = 1'b1;
      11: begin pw = 1'b1; ps = 2'b10; end
      12: begin pw = 1'b1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  // Per-cycle comparison against the expectation posted for this cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (bus.state_dbg !== exp_state[3:0]) begin
        failures++;
        $display("FAIL state t=%0t act=%0d exp=%0d", $time, bus.state_dbg, exp_state);
      end
      checks++;
      if (act_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL ctrl t=%0t state=%0d act=%b exp=%b", $time, exp_state, act_ctrl, exp_ctrl);
      end
      checks++;
      if (bus.instr_count !== exp_count) begin
        failures++;
        $display("FAIL instr_count t=%0t act=%0d exp=%0d", $time, bus.instr_count, exp_count);
      end
      checks++;
      if (bus.illegal_op !== exp_illegal) begin
        failures++;
        $display("FAIL illegal_op t=%0t act=%b exp=%b", $time, bus.illegal_op, exp_illegal);
      end
    end
  end

  task automatic pin(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, post expectation, advance past the edge
  task automatic step(input int st, input int rdy, input int subi, input int rst);
    reset         = (rst != 0);
    bus.mem_ready = (rdy != 0);
    exp_state     = st;
    exp_ctrl      = (rst != 0) ? 17'd0 : ctrl_for(st, rdy, subi);
    exp_count     = cnt_model;
    exp_illegal   = ill_model;
    exp_valid     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Expand one legal (or non-trapping illegal) instruction into its walk
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_wait, input int mem_wait);
    int subi;
    subi = (op == 6'b001001) ? 1 : 0;
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < fetch_wait; i++) step(0, 0, subi, 0);
    step(0, 1, subi, 0);
    step(1, 0, subi, 0);
    case (op)
      6'b100011: begin
        step(2, 0, subi, 0);
        for (int i = 0; i < mem_wait; i++) step(3, 0, subi, 0);
        step(3, 1, subi, 0);
        step(4, 0, subi, 0);
      end
      6'b101011: begin
        step(2, 0, subi, 0);
        for (int i = 0; i < mem_wait; i++) step(5, 0, subi, 0);
        step(5, 1, subi, 0);
      end
      6'b000000: begin
        if (fn == 6'b001000) step(12, 0, subi, 0);
        else begin step(6, 0, subi, 0); step(7, 0, subi, 0); end
      end
      6'b000100: step(8, 0, subi, 0);
      6'b001000, 6'b001001: begin step(9, 0, subi, 0); step(10, 0, subi, 0); end
      6'b000010: step(11, 0, subi, 0);
      default: ;
    endcase
    cnt_model = cnt_model + 1;
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'b0;
    bus.funct = 6'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 0, 1);            // reset held with mem_ready high: all zeros

    run_instr(6'b000000, 6'b100000, 0, 0);   // add
    pin("add_count", bus.instr_count, 32'd1);
    run_instr(6'b100011, 6'b000000, 0, 2);   // lw, two read wait states
    pin("lw_count", bus.instr_count, 32'd2);
    run_instr(6'b001001, 6'b000000, 0, 0);   // subi
    run_instr(6'b000100, 6'b000000, 0, 0);   // beq
    pin("subi_beq_count", bus.instr_count, 32'd4);
    run_instr(6'b000000, 6'b001000, 0, 0);   // jr
    run_instr(6'b000010, 6'b000000, 0, 0);   // j
    run_instr(6'b001000, 6'b000011, 1, 0);   // addi after fetch wait
    run_instr(6'b101011, 6'b000000, 2, 1);   // sw with waits
    pin("mixed_count", bus.instr_count, 32'd8);

`ifdef ILLEGAL_TRAP_EN
    bus.opcode = 6'b111111;
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ill_model = 1'b1;
    for (int i = 0; i < 4; i++) step(13, i % 2, 0, 0);
    pin("trap_flag", 32'(bus.illegal_op), 32'd1);
    pin("trap_count", bus.instr_count, 32'd8);
    step(13, 1, 0, 1);           // reset out of TRAP
    cnt_model = '0;
    ill_model = 1'b0;
    pin("trap_flag_cleared", 32'(bus.illegal_op), 32'd0);
`else
    run_instr(6'b111111, 6'b000000, 0, 0);   // illegal -> NOP
    pin("nop_count", bus.instr_count, 32'd9);
    pin("nop_flag", 32'(bus.illegal_op), 32'd0);
`endif

    // Reset while sw waits in MEM_WRITE
    bus.opcode = 6'b101011;
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(2, 0, 0, 0);
    step(5, 0, 0, 0);
    step(5, 0, 0, 0);
    step(5, 1, 0, 1);            // reset cycle: outputs gated off
    cnt_model = '0;
    pin("rst_state", 32'(bus.state_dbg), 32'd0);
    pin("rst_count", bus.instr_count, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    run_instr(6'b000000, 6'b100010, 0, 0);   // sub resumes cleanly
    pin("resume_count", bus.instr_count, 32'd1);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
